// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states and
// datapath mux/ALU selects.
package mc_pkg;

    localparam logic [2:0] OpLw  = 3'd0;
    localparam logic [2:0] OpSw  = 3'd1;
    localparam logic [2:0] OpBeq = 3'd2;
    localparam logic [2:0] OpBlt = 3'd3;
    localparam logic [2:0] OpAdd = 3'd4;
    localparam logic [2:0] OpSub = 3'd5;
    localparam logic [2:0] OpAnd = 3'd6;
    localparam logic [2:0] OpOr  = 3'd7;

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StFetch    = 4'd1,
        StDecode   = 4'd2,
        StMemAddr  = 4'd3,
        StMemRead  = 4'd4,
        StMemWb    = 4'd5,
        StMemWrite = 4'd6,
        StExecute  = 4'd7,
        StAluWb    = 4'd8,
        StBranch   = 4'd9
    } mc_state_e;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;

    localparam logic [1:0] SrcBReg = 2'b00;
    localparam logic [1:0] SrcBOne = 2'b01;
    localparam logic [1:0] SrcBImm = 2'b10;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write_en;
        logic       pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       instr_done;
    } mc_ctrl_t;

    // ALU-class opcodes (ADD..OR) map onto alu_op by their low two bits.
    function automatic logic [2:0] alu_op_of(input logic [1:0] op_low);
        return {1'b0, op_low};
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit boundary: decoder/ALU status in, datapath controls and
// performance counters out.
interface multicycle_control_if #(
    parameter int unsigned CNT_WIDTH = 32
);
    logic                 enable;
    logic [2:0]           opcode;
    logic                 mem_ready;
    logic                 alu_zero;
    logic                 alu_neg;

    logic                 ir_write;
    logic                 pc_write_en;
    logic                 pc_source;
    logic                 i_or_d;
    logic                 mem_read;
    logic                 mem_write;
    logic                 reg_write;
    logic                 reg_dst;
    logic                 mem_to_reg;
    logic                 alu_src_a;
    logic [1:0]           alu_src_b;
    logic [2:0]           alu_op;
    logic                 instr_done;
    logic [3:0]           state;
    logic [CNT_WIDTH-1:0] cycle_count;
    logic [CNT_WIDTH-1:0] instr_count;

    modport slave (
        input  enable, opcode, mem_ready, alu_zero, alu_neg,
        output ir_write, pc_write_en, pc_source, i_or_d, mem_read, mem_write,
        output reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
        output instr_done, state, cycle_count, instr_count
    );

    modport master (
        output enable, opcode, mem_ready, alu_zero, alu_neg,
        input  ir_write, pc_write_en, pc_source, i_or_d, mem_read, mem_write,
        input  reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
        input  instr_done, state, cycle_count, instr_count
    );

endinterface

// File: rtl/perf_counter.sv
// Free-running wrap-around event counter with asynchronous active-high reset.
module perf_counter #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle processor control FSM: sequences fetch/decode/execute/memory/
// writeback and drives every datapath enable and mux select.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input logic                   clk,
    input logic                   rst,
    multicycle_control_if.slave   bus
);

    mc_state_e  state_q, state_d;
    logic [2:0] op_q;
    mc_ctrl_t   ctrl;
    logic       cycle_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Opcode is latched in DECODE so EXECUTE/BRANCH never look at the live IR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= OpLw;
        end else if (state_q == StDecode) begin
            op_q <= bus.opcode;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.enable) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (bus.mem_ready) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                unique case (bus.opcode)
                    OpLw, OpSw:               state_d = StMemAddr;
                    OpBeq, OpBlt:             state_d = StBranch;
                    OpAdd, OpSub, OpAnd, OpOr: state_d = StExecute;
                    default:                  state_d = StIdle;
                endcase
            end
            StMemAddr: begin
                state_d = (bus.opcode == OpSw) ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                if (bus.mem_ready) begin
                    state_d = StMemWb;
                end
            end
            StMemWrite: begin
                if (bus.mem_ready) begin
                    state_d = bus.enable ? StFetch : StIdle;
                end
            end
            StExecute: begin
                state_d = StAluWb;
            end
            StMemWb, StAluWb, StBranch: begin
                state_d = bus.enable ? StFetch : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        ctrl = '0;
        unique case (state_q)
            StFetch: begin
                ctrl.mem_read    = 1'b1;
                ctrl.i_or_d      = 1'b0;
                ctrl.alu_src_a   = 1'b0;
                ctrl.alu_src_b   = SrcBOne;
                ctrl.alu_op      = AluAdd;
                ctrl.ir_write    = bus.mem_ready;
                ctrl.pc_write_en = bus.mem_ready;
                ctrl.pc_source   = 1'b0;
            end
            StDecode: begin
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SrcBImm;
                ctrl.alu_op    = AluAdd;
            end
            StMemAddr: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SrcBImm;
                ctrl.alu_op    = AluAdd;
            end
            StMemRead: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            StMemWb: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            StMemWrite: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = bus.mem_ready;
            end
            StExecute: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SrcBReg;
                ctrl.alu_op    = alu_op_of(op_q[1:0]);
            end
            StAluWb: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
                ctrl.instr_done = 1'b1;
            end
            StBranch: begin
                ctrl.alu_src_a   = 1'b1;
                ctrl.alu_src_b   = SrcBReg;
                ctrl.alu_op      = AluSub;
                ctrl.pc_source   = 1'b1;
                ctrl.pc_write_en = (op_q == OpBeq) ? bus.alu_zero : bus.alu_neg;
                ctrl.instr_done  = 1'b1;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

    assign bus.ir_write    = ctrl.ir_write;
    assign bus.pc_write_en = ctrl.pc_write_en;
    assign bus.pc_source   = ctrl.pc_source;
    assign bus.i_or_d      = ctrl.i_or_d;
    assign bus.mem_read    = ctrl.mem_read;
    assign bus.mem_write   = ctrl.mem_write;
    assign bus.reg_write   = ctrl.reg_write;
    assign bus.reg_dst     = ctrl.reg_dst;
    assign bus.mem_to_reg  = ctrl.mem_to_reg;
    assign bus.alu_src_a   = ctrl.alu_src_a;
    assign bus.alu_src_b   = ctrl.alu_src_b;
    assign bus.alu_op      = ctrl.alu_op;
    assign bus.instr_done  = ctrl.instr_done;
    assign bus.state       = state_q;

    assign cycle_inc = (state_q != StIdle);

    perf_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_cycle_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (cycle_inc),
        .count(bus.cycle_count)
    );

    perf_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_instr_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (ctrl.instr_done),
        .count(bus.instr_count)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle control-vector checks,
// counter model, and a latency scoreboard popped on instr_done.
module tb_multicycle_control;
    import mc_pkg::*;

    localparam int unsigned CW = 4;

    // Packed as {ir_write, pc_write_en, pc_source, i_or_d, mem_read, mem_write,
    //            reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b[1:0],
    //            alu_op[2:0], instr_done}
    localparam logic [15:0] CIdle      = 16'h0000;
    localparam logic [15:0] CFetchGo   = 16'hC810;
    localparam logic [15:0] CFetchWait = 16'h0810;
    localparam logic [15:0] CDecode    = 16'h0020;
    localparam logic [15:0] CMemAddr   = 16'h0060;
    localparam logic [15:0] CMemRead   = 16'h1800;
    localparam logic [15:0] CMemWb     = 16'h0281;
    localparam logic [15:0] CMemWrWait = 16'h1400;
    localparam logic [15:0] CMemWrGo   = 16'h1401;
    localparam logic [15:0] CAluWb     = 16'h0301;
    localparam logic [15:0] CBrNot     = 16'h2043;
    localparam logic [15:0] CBrTaken   = 16'h6043;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_control_if #(.CNT_WIDTH(CW)) bus ();

    multicycle_control #(
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    int sb[$];
    int lat;
    logic [CW-1:0] exp_cyc;
    logic [CW-1:0] exp_instr;

    function automatic logic [15:0] ctrl_vec();
        return {bus.ir_write, bus.pc_write_en, bus.pc_source, bus.i_or_d, bus.mem_read,
                bus.mem_write, bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.instr_done};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample mid-cycle, then advance the counter model across the edge.
    task automatic step(input mc_state_e exp_st, input logic [15:0] exp_ctrl, input string tag);
        int want;
        lat++;
        @(negedge clk);
        chk({tag, "_state"}, 32'(bus.state), 32'(exp_st));
        chk({tag, "_ctrl"}, 32'(ctrl_vec()), 32'(exp_ctrl));
        chk({tag, "_cyc"}, 32'(bus.cycle_count), 32'(exp_cyc));
        chk({tag, "_instr"}, 32'(bus.instr_count), 32'(exp_instr));
        if (bus.instr_done) begin
            chk({tag, "_sb_pending"}, 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                want = sb.pop_front();
                chk({tag, "_latency"}, 32'(lat), 32'(want));
            end
        end
        @(posedge clk);
        #1;
        if (exp_st != StIdle) exp_cyc++;
        if (exp_ctrl[0]) exp_instr++;
    endtask

    // Starts with the DUT in FETCH; waits apply to the data-memory state.
    task automatic do_instr(input logic [2:0] op, input int waits, input logic z,
                            input logic n, input logic keep);
        logic [15:0] ex;
        int base;
        unique case (op)
            OpLw:         base = 5;
            OpSw:         base = 4;
            OpBeq, OpBlt: base = 3;
            default:      base = 4;
        endcase
        sb.push_back(base + waits);
        lat = 0;
        bus.opcode    = op;
        bus.alu_zero  = z;
        bus.alu_neg   = n;
        bus.mem_ready = 1'b1;
        step(StFetch, CFetchGo, "fetch");
        step(StDecode, CDecode, "decode");
        bus.enable = keep;
        unique case (op)
            OpLw: begin
                step(StMemAddr, CMemAddr, "lw_addr");
                bus.mem_ready = 1'b0;
                for (int i = 0; i < waits; i++) step(StMemRead, CMemRead, "lw_rd_wait");
                bus.mem_ready = 1'b1;
                step(StMemRead, CMemRead, "lw_rd");
                step(StMemWb, CMemWb, "lw_wb");
            end
            OpSw: begin
                step(StMemAddr, CMemAddr, "sw_addr");
                bus.mem_ready = 1'b0;
                for (int i = 0; i < waits; i++) step(StMemWrite, CMemWrWait, "sw_wait");
                bus.mem_ready = 1'b1;
                step(StMemWrite, CMemWrGo, "sw_wr");
            end
            OpBeq: step(StBranch, z ? CBrTaken : CBrNot, "beq");
            OpBlt: step(StBranch, n ? CBrTaken : CBrNot, "blt");
            default: begin
                ex = 16'h0040;
                ex[3:1] = {1'b0, op[1:0]};
                step(StExecute, ex, "exec");
                step(StAluWb, CAluWb, "alu_wb");
            end
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.enable    = 1'b0;
        bus.opcode    = OpLw;
        bus.mem_ready = 1'b0;
        bus.alu_zero  = 1'b0;
        bus.alu_neg   = 1'b0;
        exp_cyc       = '0;
        exp_instr     = '0;
        lat           = 0;
        @(posedge clk);
        #1;
        step(StIdle, CIdle, "in_rst");
        rst = 1'b0;
        step(StIdle, CIdle, "idle");
        bus.enable = 1'b1;
        step(StIdle, CIdle, "idle_go");

        // Reset asserted while FETCH is waiting on memory.
        @(negedge clk);
        chk("fetch_wait_state", 32'(bus.state), 32'(StFetch));
        chk("fetch_wait_ctrl", 32'(ctrl_vec()), 32'(CFetchWait));
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_state", 32'(bus.state), 32'(StIdle));
        chk("rst_async_ctrl", 32'(ctrl_vec()), 32'(CIdle));
        chk("rst_async_cyc", 32'(bus.cycle_count), 32'd0);
        chk("rst_async_instr", 32'(bus.instr_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.enable = 1'b0;
        step(StIdle, CIdle, "idle_after_rst");

        // LW, single instruction then back to IDLE.
        bus.enable = 1'b1;
        step(StIdle, CIdle, "lw_start");
        do_instr(OpLw, 0, 1'b0, 1'b0, 1'b0);
        step(StIdle, CIdle, "lw_done");
        chk("lw_cycle_count", 32'(bus.cycle_count), 32'd5);
        chk("lw_instr_count", 32'(bus.instr_count), 32'd1);

        // SW with three wait cycles.
        bus.enable = 1'b1;
        step(StIdle, CIdle, "sw_start");
        do_instr(OpSw, 3, 1'b0, 1'b0, 1'b0);
        step(StIdle, CIdle, "sw_done");

        // Branches back to back.
        bus.enable = 1'b1;
        step(StIdle, CIdle, "br_start");
        do_instr(OpBeq, 0, 1'b1, 1'b0, 1'b1);
        do_instr(OpBeq, 0, 1'b0, 1'b1, 1'b1);
        do_instr(OpBlt, 0, 1'b1, 1'b1, 1'b1);
        do_instr(OpBlt, 0, 1'b1, 1'b0, 1'b0);
        step(StIdle, CIdle, "br_done");

        // ALU class.
        bus.enable = 1'b1;
        step(StIdle, CIdle, "alu_start");
        do_instr(OpAdd, 0, 1'b0, 1'b0, 1'b1);
        do_instr(OpSub, 0, 1'b0, 1'b0, 1'b1);
        do_instr(OpAnd, 0, 1'b0, 1'b0, 1'b1);
        do_instr(OpOr, 0, 1'b0, 1'b0, 1'b0);
        step(StIdle, CIdle, "alu_done");

        // Counter wrap: 16 ALU ops from reset, enable dropped in the last one.
        rst = 1'b1;
        #1;
        exp_cyc   = '0;
        exp_instr = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.enable = 1'b1;
        step(StIdle, CIdle, "wrap_start");
        for (int i = 0; i < 16; i++) begin
            do_instr(3'(4 + (i % 4)), 0, 1'b0, 1'b0, (i != 15));
        end
        step(StIdle, CIdle, "wrap_done");
        chk("wrap_instr_count", 32'(bus.instr_count), 32'd0);
        repeat (3) step(StIdle, CIdle, "frozen");
        chk("frozen_cycle_count", 32'(bus.cycle_count), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
